// File: rtl/core_defines_pkg.sv
// Shared core front-end definitions: hold levels, fetch defaults, RAS op codes.
package core_defines_pkg;

  localparam int unsigned HOLD_LVL_W = 3;

  // Pipeline hold levels driven by ctrl; higher levels freeze more stages.
  typedef enum logic [HOLD_LVL_W-1:0] {
    HOLD_NONE = 3'd0,
    HOLD_PC   = 3'd1,
    HOLD_IF   = 3'd2,
    HOLD_ID   = 3'd3
  } hold_lvl_e;

  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;
  localparam int unsigned DEFAULT_INSN_BYTES = 4;

  // Return-address stack operation for one accepted fetch.
  typedef enum logic [1:0] {
    RAS_IDLE = 2'd0,
    RAS_PUSH = 2'd1,
    RAS_POP  = 2'd2,
    RAS_SWAP = 2'd3
  } ras_op_e;

  // Map call/return flags of the fetched instruction onto a stack op.
  function automatic ras_op_e ras_op_decode(input logic call, input logic ret);
    ras_op_e op;
    op = RAS_IDLE;
    if (call && ret) begin
      op = RAS_SWAP;
    end else if (call) begin
      op = RAS_PUSH;
    end else if (ret) begin
      op = RAS_POP;
    end
    return op;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; oldest entry is overwritten when full.
module pc_ras
  import core_defines_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  ras_op_e         op,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  entries [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PTR_W-1:0] ptr_m1;
  logic [PTR_W-1:0] ptr_p1;

  // Neighbouring pointer values; wrap is implicit since the depth is a power of two.
  always_comb begin
    ptr_m1 = ptr_q - PTR_W'(1);
    ptr_p1 = ptr_q + PTR_W'(1);
  end

  // Flags and predicted target come straight from the stack registers.
  always_comb begin
    empty = (cnt_q == CNT_W'(0));
    full  = (cnt_q == CNT_W'(RAS_DEPTH));
    top   = entries[ptr_m1];
  end

  // Stack state update: push, pop, pop-then-push, and soft clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (clear) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      case (op)
        RAS_PUSH: begin
          entries[ptr_q] <= push_data;
          ptr_q          <= ptr_p1;
          if (!full) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RAS_POP: begin
          if (!empty) begin
            ptr_q <= ptr_m1;
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RAS_SWAP: begin
          // Pop then push collapses to a top-of-stack rewrite; on an empty
          // stack the pop is a no-op and only the push remains.
          if (!empty) begin
            entries[ptr_m1] <= push_data;
          end else begin
            entries[ptr_q] <= push_data;
            ptr_q          <= ptr_p1;
            cnt_q          <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program counter with hold/jump control, valid/ready handshake,
// debugger soft reset and return-address prediction.
module pc_sequencer
  import core_defines_pkg::DEFAULT_RESET_ADDR;
  import core_defines_pkg::DEFAULT_INSN_BYTES;
  import core_defines_pkg::ras_op_e;
  import core_defines_pkg::RAS_IDLE;
  import core_defines_pkg::ras_op_decode;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(DEFAULT_RESET_ADDR),
  parameter int unsigned     INSN_BYTES = DEFAULT_INSN_BYTES,
  parameter int unsigned     RAS_DEPTH  = 4,
  parameter int unsigned     HOLD_W     = 3,
  parameter int unsigned     HOLD_PC    = 32'(core_defines_pkg::HOLD_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_en_i,
  input  logic [XLEN-1:0]   jump_addr_i,
  input  logic [HOLD_W-1:0] hold_en_i,
  input  logic              jtag_rst_i,
  input  logic              fetch_ready_i,
  input  logic              call_i,
  input  logic              ret_i,
  output logic [XLEN-1:0]   pc_o,
  output logic              fetch_valid_o,
  output logic              ras_empty_o,
  output logic              ras_full_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            run_q;
  logic            pc_frozen;
  logic            valid;
  logic            fire;
  logic            ras_upd;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            ras_full;
  ras_op_e         ras_op;

  // Handshake terms: valid never looks at ready, so a stalled request stays put.
  always_comb begin
    pc_frozen = (hold_en_i >= HOLD_W'(HOLD_PC));
    valid     = run_q & ~jtag_rst_i & ~pc_frozen;
    fire      = valid & fetch_ready_i;
    ras_upd   = fire & ~jump_en_i;
    seq_pc    = pc_q + XLEN'(INSN_BYTES);
  end

  // Stack op only for an accepted fetch that a redirect does not squash.
  always_comb begin
    ras_op = RAS_IDLE;
    if (ras_upd) begin
      ras_op = ras_op_decode(call_i, ret_i);
    end
  end

  // Next-PC priority: soft reset, redirect, hold, predicted return, sequential.
  always_comb begin
    pc_d = pc_q;
    if (jtag_rst_i) begin
      pc_d = RESET_ADDR;
    end else if (jump_en_i) begin
      pc_d = jump_addr_i;
    end else if (pc_frozen) begin
      pc_d = pc_q;
    end else if (fire && ret_i && !ras_empty) begin
      pc_d = ras_top;
    end else if (fire) begin
      pc_d = seq_pc;
    end
  end

  // PC and run flag registers; run_q rises on the first edge out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_ADDR;
      run_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      run_q <= 1'b1;
    end
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .clear     (jtag_rst_i),
    .op        (ras_op),
    .push_data (seq_pc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  // Output drive.
  always_comb begin
    pc_o          = pc_q;
    fetch_valid_o = valid;
    ras_empty_o   = ras_empty;
    ras_full_o    = ras_full;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand sequences and a
// randomized run against a queue-based reference model.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic [2:0]  hold_en_i;
  logic        jtag_rst_i;
  logic        fetch_ready_i;
  logic        call_i;
  logic        ret_i;
  logic [31:0] pc_o;
  logic        fetch_valid_o;
  logic        ras_empty_o;
  logic        ras_full_o;

  pc_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .jump_en_i     (jump_en_i),
    .jump_addr_i   (jump_addr_i),
    .hold_en_i     (hold_en_i),
    .jtag_rst_i    (jtag_rst_i),
    .fetch_ready_i (fetch_ready_i),
    .call_i        (call_i),
    .ret_i         (ret_i),
    .pc_o          (pc_o),
    .fetch_valid_o (fetch_valid_o),
    .ras_empty_o   (ras_empty_o),
    .ras_full_o    (ras_full_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        jmp;
    logic [31:0] addr;
    logic [2:0]  hold;
    logic        jtag;
    logic        rdy;
    logic        call;
    logic        ret;
    logic [31:0] exp_pc;
    logic        exp_valid;
  } vec_t;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model state: PC, run flag and RAS as a bounded stack of addresses.
  logic [31:0] m_pc = 32'h0;
  bit          m_run = 1'b0;
  logic [31:0] m_ras [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic jmp, input logic [31:0] addr,
                              input logic [2:0] hold, input logic jtag, input logic rdy,
                              input logic call, input logic ret,
                              input logic [31:0] exp_pc, input logic exp_valid);
    vec_t v;
    v.r = r; v.jmp = jmp; v.addr = addr; v.hold = hold; v.jtag = jtag;
    v.rdy = rdy; v.call = call; v.ret = ret; v.exp_pc = exp_pc; v.exp_valid = exp_valid;
    return v;
  endfunction

  // Advance the model by one clock according to the PC/RAS rules.
  task automatic model_step(input vec_t v, input bit valid_now);
    bit          fire;
    logic [31:0] seq;
    logic [31:0] tgt;
    fire = valid_now && v.rdy;
    if (v.r) begin
      m_pc = 32'h0;
      m_run = 1'b0;
      m_ras.delete();
    end else begin
      m_run = 1'b1;
      if (v.jtag) begin
        m_pc = 32'h0;
        m_ras.delete();
      end else if (v.jmp) begin
        m_pc = v.addr;
      end else if (v.hold >= 3'd1) begin
        m_pc = m_pc;
      end else if (fire) begin
        seq = m_pc + 32'd4;
        tgt = seq;
        if (v.ret && m_ras.size() > 0) tgt = m_ras.pop_back();
        if (v.call) begin
          m_ras.push_back(seq);
          if (m_ras.size() > 4) void'(m_ras.pop_front());
        end
        m_pc = tgt;
      end
    end
  endtask

  // Drive one cycle, check valid before the edge and registered state after it.
  task automatic apply(input vec_t v, output logic vout);
    bit mv;
    rst = v.r; jump_en_i = v.jmp; jump_addr_i = v.addr; hold_en_i = v.hold;
    jtag_rst_i = v.jtag; fetch_ready_i = v.rdy; call_i = v.call; ret_i = v.ret;
    #1;
    mv = m_run && !v.jtag && (v.hold < 3'd1);
    vout = fetch_valid_o;
    check("valid_model", 32'(fetch_valid_o), 32'(mv));
    @(posedge clk);
    #1;
    model_step(v, mv);
    check("pc_model", pc_o, m_pc);
    check("empty_model", 32'(ras_empty_o), 32'(m_ras.size() == 0));
    check("full_model", 32'(ras_full_o), 32'(m_ras.size() == 4));
  endtask

  // Single control cycle with no table expectation.
  task automatic cyc(input logic jmp, input logic [31:0] addr, input logic [2:0] hold,
                     input logic jtag, input logic rdy, input logic call, input logic ret,
                     output logic vout);
    apply(mk(1'b0, jmp, addr, hold, jtag, rdy, call, ret, 32'h0, 1'b0), vout);
  endtask

  vec_t        tbl [$];
  logic        vo;
  logic [31:0] ret_exp [4];

  initial begin
    rst = 1'b1; jump_en_i = 1'b0; jump_addr_i = 32'h0; hold_en_i = 3'd0;
    jtag_rst_i = 1'b0; fetch_ready_i = 1'b1; call_i = 1'b0; ret_i = 1'b0;
    @(posedge clk);
    #1;

    // Reset release, sequential fetch, ready stall, hold with redirect.
    tbl.push_back(mk(1, 0, 32'h0,   3'd0, 0, 1, 0, 0, 32'h0,   0));
    tbl.push_back(mk(1, 0, 32'h0,   3'd0, 0, 1, 0, 0, 32'h0,   0));
    tbl.push_back(mk(1, 0, 32'h0,   3'd0, 0, 1, 0, 0, 32'h0,   0));
    tbl.push_back(mk(0, 0, 32'h0,   3'd0, 0, 1, 0, 0, 32'h0,   0));
    tbl.push_back(mk(0, 0, 32'h0,   3'd0, 0, 1, 0, 0, 32'h4,   1));
    tbl.push_back(mk(0, 0, 32'h0,   3'd0, 0, 1, 0, 0, 32'h8,   1));
    tbl.push_back(mk(0, 0, 32'h0,   3'd0, 0, 1, 0, 0, 32'hC,   1));
    tbl.push_back(mk(0, 0, 32'h0,   3'd0, 0, 1, 0, 0, 32'h10,  1));
    tbl.push_back(mk(0, 0, 32'h0,   3'd0, 0, 0, 0, 0, 32'h10,  1));
    tbl.push_back(mk(0, 0, 32'h0,   3'd0, 0, 0, 0, 0, 32'h10,  1));
    tbl.push_back(mk(0, 0, 32'h0,   3'd0, 0, 0, 0, 0, 32'h10,  1));
    tbl.push_back(mk(0, 0, 32'h0,   3'd0, 0, 0, 0, 0, 32'h10,  1));
    tbl.push_back(mk(0, 0, 32'h0,   3'd0, 0, 1, 0, 0, 32'h14,  1));
    tbl.push_back(mk(0, 1, 32'h200, 3'd1, 0, 1, 0, 0, 32'h200, 0));
    tbl.push_back(mk(0, 0, 32'h0,   3'd1, 0, 1, 0, 0, 32'h200, 0));
    tbl.push_back(mk(0, 0, 32'h0,   3'd3, 0, 1, 1, 0, 32'h200, 0));
    tbl.push_back(mk(0, 0, 32'h0,   3'd0, 0, 1, 0, 0, 32'h204, 1));
    foreach (tbl[i]) begin
      apply(tbl[i], vo);
      check($sformatf("tbl%0d_valid", i), 32'(vo), 32'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_pc", i), pc_o, tbl[i].exp_pc);
    end

    // Nested calls and returns, then a return on an empty stack.
    cyc(1, 32'h100, 0, 0, 0, 0, 0, vo);
    cyc(0, 32'h0,   0, 0, 1, 1, 0, vo);
    check("t4_call1_pc", pc_o, 32'h104);
    cyc(1, 32'h200, 0, 0, 0, 0, 0, vo);
    cyc(0, 32'h0,   0, 0, 1, 1, 0, vo);
    cyc(1, 32'h300, 0, 0, 0, 0, 0, vo);
    cyc(0, 32'h0,   0, 0, 1, 0, 1, vo);
    check("t4_ret1", pc_o, 32'h204);
    cyc(0, 32'h0,   0, 0, 1, 0, 1, vo);
    check("t4_ret2", pc_o, 32'h104);
    check("t4_empty", 32'(ras_empty_o), 32'd1);
    cyc(1, 32'h300, 0, 0, 0, 0, 0, vo);
    cyc(0, 32'h0,   0, 0, 1, 0, 1, vo);
    check("t4_ret3_seq", pc_o, 32'h304);

    // Overflow: five calls on a four-deep stack drop the oldest.
    for (int i = 0; i < 5; i++) begin
      cyc(1, 32'(i * 16), 0, 0, 0, 0, 0, vo);
      cyc(0, 32'h0,       0, 0, 1, 1, 0, vo);
    end
    check("t5_full", 32'(ras_full_o), 32'd1);
    ret_exp[0] = 32'h44; ret_exp[1] = 32'h34; ret_exp[2] = 32'h24; ret_exp[3] = 32'h14;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 32'h0, 0, 0, 1, 0, 1, vo);
      check($sformatf("t5_ret%0d", i), pc_o, ret_exp[i]);
    end
    check("t5_empty", 32'(ras_empty_o), 32'd1);

    // Address wrap, then soft reset with entries on the stack.
    cyc(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, vo);
    cyc(0, 32'h0,         0, 0, 1, 0, 0, vo);
    check("t6_wrap", pc_o, 32'h0);
    cyc(0, 32'h0, 0, 0, 1, 1, 0, vo);
    cyc(0, 32'h0, 0, 0, 1, 1, 0, vo);
    check("t6_two_entries", 32'(ras_empty_o), 32'd0);
    cyc(0, 32'h0, 0, 1, 1, 1, 0, vo);
    check("t6_jtag_valid", 32'(vo), 32'd0);
    check("t6_jtag_pc", pc_o, 32'h0);
    check("t6_jtag_empty", 32'(ras_empty_o), 32'd1);
    cyc(0, 32'h0, 0, 0, 0, 0, 0, vo);
    check("t6_run_kept", 32'(vo), 32'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      vec_t v;
      v.r    = ($urandom_range(0, 99) == 0);
      v.jtag = ($urandom_range(0, 49) == 0);
      v.jmp  = ($urandom_range(0, 7) == 0);
      v.addr = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : {$urandom_range(0, 32'h3FFF), 2'b00};
      v.hold = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      v.rdy  = ($urandom_range(0, 3) != 0);
      v.call = ($urandom_range(0, 2) == 0);
      v.ret  = ($urandom_range(0, 2) == 0);
      v.exp_pc = 32'h0;
      v.exp_valid = 1'b0;
      apply(v, vo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
